// File: rtl/jstk2_spi_scheduler.sv
// jstk2_spi_scheduler: sequences 5-byte PmodJSTK2 SPI frames (position polls and RGB LED writes)
module jstk2_spi_scheduler #(
  parameter int POLL_CYCLES     = 120000,
  parameter int SS_SETUP_CYCLES = 180,
  parameter int BYTE_GAP_CYCLES = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] rgb_in,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic        spi_busy,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,
  output logic        ss_n,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [1:0]  jstk_btn,
  output logic        data_valid,
  output logic        busy
);
  localparam int CW = $clog2(POLL_CYCLES + SS_SETUP_CYCLES + BYTE_GAP_CYCLES + 1);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT, GAP, FINISH, RECOVER} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] idx;
  logic [23:0] last_sent, tx_rgb;
  logic dirty, is_color, pend;
  logic [7:0] rx0, rx2;
  logic [1:0] rx1, rx3;
  assign pend = dirty || rgb_in != last_sent;
  assign spi_start = state == SEND && !spi_busy;
  assign data_valid = state == FINISH;
  assign busy = state != IDLE;
  assign spi_tx = !is_color     ? 8'h00 :
                  idx == 3'd0   ? 8'h84 :
                  idx == 3'd1   ? tx_rgb[23:16] :
                  idx == 3'd2   ? tx_rgb[15:8] :
                  idx == 3'd3   ? tx_rgb[7:0] : 8'h00;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt + 1'b1;
    case (state)
      IDLE:    if (pend || cnt == POLL_LAST) state_nx = SETUP;
      SETUP:   if (cnt >= SETUP_LAST) state_nx = SEND;
      SEND:    if (!spi_busy) state_nx = WAIT;
      WAIT:    if (spi_done) state_nx = idx == 3'd4 ? FINISH : GAP;
      GAP:     if (cnt >= GAP_LAST) state_nx = SEND;
      FINISH:  state_nx = RECOVER;
      RECOVER: if (cnt >= SETUP_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // the spi_done cycle already counts as the first gap clock
    if (state_nx != state) cnt_nx = state_nx == GAP ? CW'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      ss_n <= 1'b1;
      last_sent <= '0;
      tx_rgb <= '0;
      dirty <= 1'b1;
      is_color <= 1'b0;
      rx0 <= '0;
      rx1 <= '0;
      rx2 <= '0;
      rx3 <= '0;
      x_pos <= '0;
      y_pos <= '0;
      jstk_btn <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ss_n <= !(state_nx inside {SETUP, SEND, WAIT, GAP});
      if (state == IDLE && state_nx == SETUP) begin
        idx <= '0;
        is_color <= pend;
        if (pend) begin
          tx_rgb <= rgb_in;
          last_sent <= rgb_in;
          dirty <= 1'b0;
        end
      end
      if (state == WAIT && spi_done) begin
        if (idx == 3'd0) rx0 <= spi_rx;
        if (idx == 3'd1) rx1 <= spi_rx[1:0];
        if (idx == 3'd2) rx2 <= spi_rx;
        if (idx == 3'd3) rx3 <= spi_rx[1:0];
        if (idx != 3'd4) idx <= idx + 3'd1;
        // last byte goes straight from spi_rx so the frame commits as FINISH begins
        if (idx == 3'd4) begin
          x_pos <= {rx1, rx0};
          y_pos <= {rx3, rx2};
          jstk_btn <= spi_rx[1:0];
        end
      end
    end
endmodule

// File: tb/tb_jstk2_spi_scheduler.sv
// tb_jstk2_spi_scheduler: timeline model of frame timing, bytes and decode checked every cycle
module tb_jstk2_spi_scheduler;
  logic clk = 0, rst_n = 0;
  logic [23:0] rgb_in = 24'h7F0000;
  logic spi_start, ss_n, data_valid, busy;
  logic [7:0] spi_tx;
  logic spi_busy = 0, spi_done = 0;
  logic [7:0] spi_rx = 0;
  logic [9:0] x_pos, y_pos;
  logic [1:0] jstk_btn;
  int checks = 0, errors = 0, cyc = 0;
  int eng_start_at = -100, eng_done_at = -100, spur_at = -100, xb_from = -100, xb_to = -100;
  logic [7:0] eng_rx = 0;
  logic [7:0] rx_pat [5] = '{8'h34, 8'h02, 8'h10, 8'h01, 8'h03};
  int fall_cyc[$], dv_cyc[$], first_start[$], start_cyc[$], hi_before[$];
  logic [7:0] tx_log[$];
  int fr_starts = 0, fr_dones = 0, hi_run = 0;
  logic prev_ss_n = 1;
  bit m_in = 0, m_wait = 0, m_dirty = 1;
  int m_due = -1, m_idle_start = 0, m_end = -1, m_nst = 0, m_nd = 0;
  logic [7:0] m_frame [5], m_rx [5];
  logic [23:0] m_last = 0;
  logic [9:0] m_x = 0, m_y = 0, p_x = 0, p_y = 0;
  logic [1:0] m_b = 0, p_b = 0;

  jstk2_spi_scheduler #(.POLL_CYCLES(1000), .SS_SETUP_CYCLES(4), .BYTE_GAP_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .spi_start(spi_start), .spi_tx(spi_tx),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx(spi_rx), .ss_n(ss_n), .x_pos(x_pos),
    .y_pos(y_pos), .jstk_btn(jstk_btn), .data_valid(data_valid), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic int val(input int what);
    case (what)
      0: return dv_cyc.size();
      1: return fall_cyc.size();
      2: return fr_starts;
      default: return fr_dones;
    endcase
  endfunction

  task automatic wait_for(input string name, input int what, input int n, input int limit);
    int k = 0;
    while (val(what) < n && k < limit) begin
      tick();
      k++;
    end
    chk({"wait_", name}, 32'(val(what) >= n), 1);
  endtask

  task automatic chk_frame(input string name, input int base, input logic [39:0] exp);
    chk({name, "_len"}, 32'(tx_log.size() >= base + 5), 1);
    for (int i = 0; i < 5; i++)
      if (base + i < tx_log.size()) chk(name, tx_log[base + i], exp[39 - 8 * i -: 8]);
  endtask

  // SPI engine: done 10 clocks after start, busy in between; plus injected busy/done
  initial forever begin
    @(posedge clk);
    #1;
    spi_done = (cyc == eng_done_at) || (cyc == spur_at);
    spi_rx = (cyc == eng_done_at) ? eng_rx : 8'hEE;
    spi_busy = (cyc > eng_start_at && cyc < eng_done_at) || (cyc >= xb_from && cyc <= xb_to);
  end

  always @(negedge clk) begin
    bit idle, exp_start;
    if (!rst_n) begin
      m_in = 0; m_wait = 0; m_due = -1; m_idle_start = cyc + 1; m_end = -1;
      m_last = 0; m_dirty = 1; m_x = 0; m_y = 0; m_b = 0;
      chk("rst_ss_n", ss_n, 1);
      chk("rst_busy", busy, 0);
      chk("rst_spi_start", spi_start, 0);
      chk("rst_spi_tx", spi_tx, 0);
      chk("rst_data_valid", data_valid, 0);
      chk("rst_x_pos", x_pos, 0);
      chk("rst_y_pos", y_pos, 0);
      chk("rst_btn", jstk_btn, 0);
    end else begin
      idle = !m_in && cyc >= m_idle_start;
      if (cyc == m_end) begin m_x = p_x; m_y = p_y; m_b = p_b; end
      exp_start = m_in && !m_wait && m_due >= 0 && cyc >= m_due && !spi_busy;
      chk("ss_n", ss_n, !m_in);
      chk("busy", busy, !idle);
      chk("data_valid", data_valid, cyc == m_end);
      chk("spi_start", spi_start, exp_start);
      chk("x_pos", x_pos, m_x);
      chk("y_pos", y_pos, m_y);
      chk("jstk_btn", jstk_btn, m_b);
      if (exp_start && spi_start) chk("spi_tx", spi_tx, m_frame[m_nst]);
      if (m_wait && spi_done) begin
        m_rx[m_nd] = spi_rx;
        m_nd++;
        m_wait = 0;
        if (m_nd == 5) begin
          m_in = 0;
          m_end = cyc + 1;
          m_idle_start = cyc + 6;
          p_x = 10'(int'(m_rx[1] % 8'd4) * 256 + int'(m_rx[0]));
          p_y = 10'(int'(m_rx[3] % 8'd4) * 256 + int'(m_rx[2]));
          p_b = 2'(m_rx[4] % 8'd4);
        end else m_due = cyc + 3;
      end else if (exp_start) begin
        m_wait = 1;
        m_due = -1;
        m_nst++;
      end
      if (idle && (m_dirty || rgb_in != m_last || cyc - m_idle_start == 999)) begin
        if (m_dirty || rgb_in != m_last) begin
          m_frame = '{8'h84, rgb_in[23:16], rgb_in[15:8], rgb_in[7:0], 8'h00};
          m_last = rgb_in;
          m_dirty = 0;
        end else m_frame = '{default: 8'h00};
        m_in = 1; m_due = cyc + 5; m_nst = 0; m_nd = 0;
      end
    end
    if (spi_start) begin
      eng_start_at = cyc;
      eng_done_at = cyc + 10;
      eng_rx = rx_pat[fr_starts % 5];
      tx_log.push_back(spi_tx);
      start_cyc.push_back(cyc);
      if (fr_starts == 0) first_start.push_back(cyc);
      fr_starts++;
    end
    if (spi_done && cyc == eng_done_at) fr_dones++;
    if (data_valid) dv_cyc.push_back(cyc);
    if (ss_n) begin
      hi_run++;
      fr_starts = 0;
      fr_dones = 0;
    end else begin
      if (prev_ss_n) begin
        fall_cyc.push_back(cyc);
        hi_before.push_back(hi_run);
      end
      hi_run = 0;
    end
    prev_ss_n = ss_n;
  end

  initial begin
    tick();
    tick();
    @(posedge clk);
    #1 rst_n = 1;
    wait_for("dv1", 0, 1, 200);
    chk_frame("frame1_color", 0, 40'h847F000000);
    if (first_start.size() > 0 && fall_cyc.size() > 0)
      chk("setup_latency", first_start[0] - fall_cyc[0], 4);
    wait_for("dv2", 0, 2, 1300);
    chk_frame("frame2_poll", 5, 40'h0);
    if (fall_cyc.size() > 1) chk("poll_period", fall_cyc[1] - dv_cyc[0], 1005);
    chk("x_pos_a", x_pos, 10'h234);
    chk("y_pos_a", y_pos, 10'h110);
    chk("btn_a", jstk_btn, 2'b11);
    if (start_cyc.size() > 1) chk("byte_gap", start_cyc[1] - start_cyc[0], 13);
    rx_pat = '{8'hA5, 8'h01, 8'h5A, 8'h02, 8'h01};
    wait_for("fall3", 1, 3, 1300);
    wait_for("byte2", 2, 3, 100);
    rgb_in = 24'h00007F;
    wait_for("dv3", 0, 3, 300);
    chk_frame("frame3_poll", 10, 40'h0);
    chk("x_pos_b", x_pos, 10'h1A5);
    chk("y_pos_b", y_pos, 10'h25A);
    chk("btn_b", jstk_btn, 2'b01);
    wait_for("dv4", 0, 4, 300);
    chk_frame("frame4_color", 15, 40'h8400007F00);
    if (fall_cyc.size() > 3) begin
      chk("b2b_start", fall_cyc[3] - dv_cyc[2], 6);
      chk("ss_high_run", hi_before[3], 6);
    end
    wait_for("fall5", 1, 5, 1300);
    if (fall_cyc.size() > 4) begin
      xb_from = fall_cyc[4] + 1;
      xb_to = fall_cyc[4] + 20;
    end
    wait_for("done5", 3, 1, 100);
    spur_at = cyc + 1;
    if (first_start.size() > 4) chk("busy_hold", first_start[4] - fall_cyc[4], 21);
    wait_for("dv5", 0, 5, 300);
    chk("x_pos_c", x_pos, 10'h1A5);
    wait_for("fall6", 1, 6, 1300);
    wait_for("done6_3", 3, 4, 200);
    tick();
    rst_n = 0;
    tick();
    tick();
    tick();
    chk("abort_x_pos", x_pos, 0);
    chk("abort_no_dv", dv_cyc.size(), 5);
    chk("abort_ss_n", ss_n, 1);
    @(posedge clk);
    #1 rst_n = 1;
    wait_for("dv6", 0, 6, 300);
    chk_frame("frame6_color", tx_log.size() - 5, 40'h8400007F00);
    chk("setup_latency_rst", first_start[first_start.size() - 1] - fall_cyc[fall_cyc.size() - 1], 4);
    repeat (20) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
